// File: rtl/seq_detector.sv
// seq_detector: parameterised serial pattern detector (Moore, KMP fallback).
// Optional match counter is enabled by defining MATCH_COUNTER_EN.
`default_nettype none

module seq_detector #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b011,
  parameter int             OVERLAP = 1,
  parameter int             CW      = 8,
  localparam int            SW      = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          w,
  input  logic          count_clr,
  output logic          z,
  output logic [SW-1:0] state,
  output logic [CW-1:0] match_count
);

  localparam int TW = 2 * (N + 1) * SW;

  typedef enum logic [SW-1:0] {
    S0 = '0,
    SN = SW'(N)
  } state_e;

  // Longest j such that the last j bits of (PATTERN prefix of length k, then b)
  // equal the first j pattern bits; j is capped at N.
  function automatic logic [SW-1:0] fallback(input int k, input logic b);
    logic [8:0] hist;
    logic       ok;
    int         len;
    int         best;
    hist = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < k) hist[i] = PATTERN[N-1-i];
    end
    hist[k] = b;
    len  = k + 1;
    best = 0;
    for (int j = 1; j <= 8; j++) begin
      if (j <= N && j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (i < j && hist[len-j+i] != PATTERN[N-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best[SW-1:0];
  endfunction

  // Entry {k,b} holds the next state from Sk on input b; non-overlap restarts SN from S0.
  function automatic logic [TW-1:0] build_table();
    logic [TW-1:0] t;
    int            src;
    t = '0;
    for (int k = 0; k <= N; k++) begin
      for (int b = 0; b < 2; b++) begin
        src = (k == N && OVERLAP == 0) ? 0 : k;
        t[(2*k+b)*SW +: SW] = fallback(src, b[0]);
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] NEXT_TBL = build_table();

  state_e state_r;
  state_e next_state;
  int     tbl_idx;

  always_comb begin
    next_state = S0;
    tbl_idx    = 2 * int'(state_r) + int'(w);
    if (state_r <= SN) begin
      next_state = state_e'(NEXT_TBL[tbl_idx*SW +: SW]);
    end
  end

`ifdef MATCH_COUNTER_EN
  logic [CW-1:0] count_r;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S0;
      z       <= 1'b0;
`ifdef MATCH_COUNTER_EN
      count_r <= '0;
`endif
    end else if (en) begin
      state_r <= next_state;
      z       <= (next_state == SN);
`ifdef MATCH_COUNTER_EN
      // Clear wins over a simultaneous match; the counter saturates at all ones.
      if (count_clr) begin
        count_r <= '0;
      end else if (next_state == SN && count_r != {CW{1'b1}}) begin
        count_r <= count_r + CW'(1);
      end
`endif
    end
  end

  assign state = state_r;

`ifdef MATCH_COUNTER_EN
  assign match_count = count_r;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count      = '0;
`endif

endmodule

`default_nettype wire

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter N, default 3: pattern length in bits, legal range 2..8.
REQ-002 Parameter PATTERN, default 3'b011: target sequence; bit N-1 is the first bit received, bit 0 the last.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = non-overlapping.
REQ-004 Parameter CW, default 8: match counter width.
REQ-005 clock  input  1  sole clock, rising-edge active.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  sample enable; w is consumed only on edges where en=1.
REQ-008 w  input  1  serial data bit.
REQ-009 count_clr  input  1  synchronous clear of match_count.
REQ-010 z  output  1  Moore match flag.
REQ-011 state  output  SW=$clog2(N+1)  current state, equal to the number of pattern bits matched (debug).
REQ-012 match_count  output  CW  number of completed matches.

Function
REQ-013 States S0..SN; Sk means the last k accepted bits equal PATTERN[N-1 : N-k].
REQ-014 From Sk with k<N: if w==PATTERN[N-1-k], next state is S(k+1); otherwise next state is the longest j<=k such that the last j accepted bits, including w, equal PATTERN[N-1 : N-j] (KMP fallback; S0 when j=0).
REQ-015 From SN with OVERLAP=1: next state follows the same fallback over the full history, so the suffix of a completed match is reused.
REQ-016 From SN with OVERLAP=0: history is discarded and the next state is computed as from S0 with the current w.
REQ-017 Fallback targets are computed at elaboration time from PATTERN and N; there is no runtime pattern table.
REQ-018 z = 1 exactly while state==SN: a Moore output, registered, with no combinational path from w.
REQ-019 z therefore rises on the cycle after the edge that accepts the last pattern bit (1-cycle latency).
REQ-020 z stays high on consecutive cycles when the next state is again SN (e.g. PATTERN all ones with OVERLAP=1).
REQ-021 en=0: state, z and match_count hold, and w is ignored.
REQ-022 Unused state encodings (N+1 .. 2^SW-1) return to S0 on the next enabled edge.

Reset
REQ-023 reset=1 asynchronously forces state=S0, z=0 and match_count=0, regardless of clock and en.
REQ-024 Reset asserted mid-pattern discards partial progress.
REQ-025 The first enabled edge after reset deassertion evaluates w from S0.

Configuration
REQ-026 Macro MATCH_COUNTER_EN controls the match counter.
REQ-027 With MATCH_COUNTER_EN defined, match_count increments by 1 on every enabled edge whose next state is SN.
REQ-028 With MATCH_COUNTER_EN defined, match_count saturates at 2^CW-1 and never wraps.
REQ-029 With MATCH_COUNTER_EN defined, count_clr=1 sets match_count to 0 on that edge, and clear has priority over an increment on the same edge.
REQ-030 Without MATCH_COUNTER_EN, match_count is tied to 0, count_clr is ignored, and no counter flops are synthesised.
REQ-031 State and z behaviour are identical with and without MATCH_COUNTER_EN.

Verification
REQ-032 N=4, PATTERN=4'b1101, OVERLAP=1, en=1, w=1,1,0,1,1,0,1 -> z high on the cycles after bit 4 and bit 7; match_count=2.
REQ-033 Same stimulus with OVERLAP=0 -> z high only after bit 4; state after bit 7 is S1; match_count=1.
REQ-034 N=3, PATTERN=3'b111, OVERLAP=1, w=1 for 6 edges -> z high after edges 3 through 6 continuously; match_count=4.
REQ-035 Default parameters, w=0,1 then en=0 for 5 cycles then en=1 with w=1 -> state holds S2 while en=0; z=1 after the final edge.
REQ-036 reset pulsed asynchronously between edges while state=S2 -> state=S0, z=0 and match_count=0 immediately, without waiting for a clock edge.
REQ-037 CW=2, MATCH_COUNTER_EN defined, 5 matches -> match_count saturates at 3; count_clr=1 on the edge of a 6th match -> match_count=0 while z=1.
